// File: rtl/ddr3_cmd_gen.sv
// DDR3 command generator: round-robin arbitration of bank FSM requests with tRRD/tCCD/tWTR
// spacing and registered command pins. Define DDR3_CMD_GEN_REFRESH_EN for the auto-refresh scheduler.

package ddr3_cmd_gen_pkg;
  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_ACT   = 3'd1,
    CMD_READ  = 3'd2,
    CMD_WRITE = 3'd3,
    CMD_PRE   = 3'd4,
    CMD_REF   = 3'd5
  } ddr3_cmd_t;
endpackage

module ddr3_cmd_gen
  import ddr3_cmd_gen_pkg::*;
#(
  parameter int NUM_BANKS    = 4,
  parameter int ADDR_WIDTH   = 14,
  parameter int TRRD_CYCLES  = 4,
  parameter int TCCD_CYCLES  = 4,
  parameter int TWTR_CYCLES  = 4,
  parameter int TREFI_CYCLES = 6240,
  parameter int TRFC_CYCLES  = 88
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_BANKS-1:0]         bank_cmd_valid,
  input  ddr3_cmd_t                    bank_cmd_type [NUM_BANKS],
  input  logic [ADDR_WIDTH-1:0]        bank_cmd_addr [NUM_BANKS],
  input  logic [NUM_BANKS-1:0]         bank_busy,
  output logic [NUM_BANKS-1:0]         bank_cmd_grant,
  output logic                         ddr3_cs_n,
  output logic                         ddr3_ras_n,
  output logic                         ddr3_cas_n,
  output logic                         ddr3_we_n,
  output logic [$clog2(NUM_BANKS)-1:0] ddr3_ba,
  output logic [ADDR_WIDTH-1:0]        ddr3_addr,
  output logic                         ref_busy,
  output logic                         ref_overrun
);

  localparam int BAW  = $clog2(NUM_BANKS);
  localparam int TMAX = (TRRD_CYCLES > TCCD_CYCLES)
                      ? ((TRRD_CYCLES > TWTR_CYCLES) ? TRRD_CYCLES : TWTR_CYCLES)
                      : ((TCCD_CYCLES > TWTR_CYCLES) ? TCCD_CYCLES : TWTR_CYCLES);
  localparam int CNTW = $clog2(TMAX + 1);

  typedef logic [CNTW-1:0] cnt_t;
  localparam cnt_t TRRD_LOAD = cnt_t'(TRRD_CYCLES - 1);
  localparam cnt_t TCCD_LOAD = cnt_t'(TCCD_CYCLES - 1);
  localparam cnt_t TWTR_LOAD = cnt_t'(TWTR_CYCLES - 1);
  localparam cnt_t CNT_ONE   = cnt_t'(1);

  typedef struct packed {
    logic                  cs_n;
    logic                  ras_n;
    logic                  cas_n;
    logic                  we_n;
    logic [BAW-1:0]        ba;
    logic [ADDR_WIDTH-1:0] addr;
  } pins_t;

  pins_t          pins_q, pins_d;
  logic [BAW-1:0] rr_ptr_q, rr_ptr_d;
  cnt_t           trrd_q, trrd_d, tccd_q, tccd_d, twtr_q, twtr_d;

  logic [NUM_BANKS-1:0] eligible, grant;
  logic                 gnt_found;
  logic [BAW-1:0]       gnt_idx, scan_idx;
  ddr3_cmd_t            gnt_type;
  logic                 act_block, grant_block, ref_issue;

  // Eligibility and round-robin search starting at the pointer.
  always_comb begin
    // NOTE: every comb output gets a default before any branch, so no latches are inferred.
    eligible = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_cmd_valid[BAW'(b)]) begin
        case (bank_cmd_type[BAW'(b)])
          CMD_ACT:   eligible[BAW'(b)] = (trrd_q == '0) && !act_block;
          CMD_READ:  eligible[BAW'(b)] = (tccd_q == '0) && (twtr_q == '0);
          CMD_WRITE: eligible[BAW'(b)] = (tccd_q == '0);
          CMD_PRE:   eligible[BAW'(b)] = 1'b1;
          default:   eligible[BAW'(b)] = 1'b0;
        endcase
      end
    end
    if (grant_block) eligible = '0;

    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      scan_idx = BAW'((int'(rr_ptr_q) + i) % NUM_BANKS);
      if (!gnt_found && eligible[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
    grant = '0;
    if (gnt_found) grant[gnt_idx] = 1'b1;
    gnt_type = gnt_found ? bank_cmd_type[gnt_idx] : CMD_NOP;
  end

  // Reset must withdraw the grant at once, even though the request inputs may still be high.
  assign bank_cmd_grant = grant & {NUM_BANKS{rst_n}};

  always_comb begin
    pins_d = pins_q;
    pins_d.cs_n = 1'b0;
    {pins_d.ras_n, pins_d.cas_n, pins_d.we_n} = 3'b111;
    rr_ptr_d = rr_ptr_q;
    trrd_d = (trrd_q != '0) ? trrd_q - CNT_ONE : trrd_q;
    tccd_d = (tccd_q != '0) ? tccd_q - CNT_ONE : tccd_q;
    twtr_d = (twtr_q != '0) ? twtr_q - CNT_ONE : twtr_q;
    if (gnt_found) begin
      rr_ptr_d = (gnt_idx == BAW'(NUM_BANKS - 1)) ? '0 : gnt_idx + BAW'(1);
      pins_d.ba   = gnt_idx;
      pins_d.addr = bank_cmd_addr[gnt_idx];
      case (gnt_type)
        CMD_ACT: begin
          {pins_d.ras_n, pins_d.cas_n, pins_d.we_n} = 3'b011;
          trrd_d = TRRD_LOAD;
        end
        CMD_READ: begin
          {pins_d.ras_n, pins_d.cas_n, pins_d.we_n} = 3'b101;
          tccd_d = TCCD_LOAD;
        end
        CMD_WRITE: begin
          {pins_d.ras_n, pins_d.cas_n, pins_d.we_n} = 3'b100;
          tccd_d = TCCD_LOAD;
          twtr_d = TWTR_LOAD;
        end
        CMD_PRE: {pins_d.ras_n, pins_d.cas_n, pins_d.we_n} = 3'b010;
        default: ;
      endcase
    end else if (ref_issue) begin
      {pins_d.ras_n, pins_d.cas_n, pins_d.we_n} = 3'b001;
      pins_d.ba   = '0;
      pins_d.addr = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      pins_q   <= '{cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1, ba: '0, addr: '0};
      rr_ptr_q <= '0;
      trrd_q   <= '0;
      tccd_q   <= '0;
      twtr_q   <= '0;
    end else begin
      pins_q   <= pins_d;
      rr_ptr_q <= rr_ptr_d;
      trrd_q   <= trrd_d;
      tccd_q   <= tccd_d;
      twtr_q   <= twtr_d;
    end
  end

  assign ddr3_cs_n  = pins_q.cs_n;
  assign ddr3_ras_n = pins_q.ras_n;
  assign ddr3_cas_n = pins_q.cas_n;
  assign ddr3_we_n  = pins_q.we_n;
  assign ddr3_ba    = pins_q.ba;
  assign ddr3_addr  = pins_q.addr;

`ifdef DDR3_CMD_GEN_REFRESH_EN
  localparam int REFIW = $clog2(TREFI_CYCLES + 1);
  localparam int RFCW  = $clog2(TRFC_CYCLES + 1);
  localparam logic [REFIW-1:0] REFI_LOAD = REFIW'(TREFI_CYCLES - 1);
  localparam logic [RFCW-1:0]  RFC_LOAD  = RFCW'(TRFC_CYCLES);

  logic [REFIW-1:0] refi_q, refi_d;
  logic [RFCW-1:0]  rfc_q, rfc_d;
  logic             ref_pending_q, ref_pending_d, ref_overrun_q, ref_overrun_d;

  assign act_block   = ref_pending_q;
  assign grant_block = (rfc_q != '0);
  // REFRESH only takes an otherwise idle command slot with every bank closed.
  assign ref_issue   = ref_pending_q && (bank_busy == '0) && !gnt_found && (rfc_q == '0);

  always_comb begin
    refi_d        = (refi_q == '0) ? REFI_LOAD : refi_q - REFIW'(1);
    rfc_d         = ref_issue ? RFC_LOAD : ((rfc_q != '0) ? rfc_q - RFCW'(1) : rfc_q);
    ref_pending_d = ref_pending_q;
    ref_overrun_d = ref_overrun_q;
    if (ref_issue) ref_pending_d = 1'b0;
    if (refi_q == '0) begin
      ref_pending_d = 1'b1;
      if (ref_pending_q) ref_overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refi_q        <= REFI_LOAD;
      rfc_q         <= '0;
      ref_pending_q <= 1'b0;
      ref_overrun_q <= 1'b0;
    end else begin
      refi_q        <= refi_d;
      rfc_q         <= rfc_d;
      ref_pending_q <= ref_pending_d;
      ref_overrun_q <= ref_overrun_d;
    end
  end

  assign ref_busy    = ref_pending_q | (rfc_q != '0);
  assign ref_overrun = ref_overrun_q;
`else
  logic unused_bank_busy;
  assign unused_bank_busy = ^bank_busy;
  assign act_block   = 1'b0;
  assign grant_block = 1'b0;
  assign ref_issue   = 1'b0;
  assign ref_busy    = 1'b0;
  assign ref_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_cmd_gen.sv
// Scoreboard bench for ddr3_cmd_gen: a cycle-numbered reference model pushes expected grants and pins,
// a negedge monitor pops and compares. Refresh checks are active when DDR3_CMD_GEN_REFRESH_EN is defined.

module tb_ddr3_cmd_gen;
  import ddr3_cmd_gen_pkg::*;

  localparam int NB = 4, BW = 2, AW = 14;
  localparam int TRRD = 4, TCCD = 4, TWTR = 6, TREFI = 20, TRFC = 8;
`ifdef DDR3_CMD_GEN_REFRESH_EN
  localparam bit REF_EN = 1'b1;
`else
  localparam bit REF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NB-1:0] bank_cmd_valid = '0;
  logic [NB-1:0] bank_busy = '0;
  logic [NB-1:0] bank_cmd_grant;
  ddr3_cmd_t     bank_cmd_type [NB] = '{default: CMD_NOP};
  logic [AW-1:0] bank_cmd_addr [NB] = '{default: '0};
  logic          ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n;
  logic [BW-1:0] ddr3_ba;
  logic [AW-1:0] ddr3_addr;
  logic          ref_busy, ref_overrun;

  always #5 clk = ~clk;

  ddr3_cmd_gen #(
    .NUM_BANKS(NB), .ADDR_WIDTH(AW), .TRRD_CYCLES(TRRD), .TCCD_CYCLES(TCCD),
    .TWTR_CYCLES(TWTR), .TREFI_CYCLES(TREFI), .TRFC_CYCLES(TRFC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bank_cmd_valid(bank_cmd_valid), .bank_cmd_type(bank_cmd_type),
    .bank_cmd_addr(bank_cmd_addr), .bank_busy(bank_busy), .bank_cmd_grant(bank_cmd_grant),
    .ddr3_cs_n(ddr3_cs_n), .ddr3_ras_n(ddr3_ras_n), .ddr3_cas_n(ddr3_cas_n), .ddr3_we_n(ddr3_we_n),
    .ddr3_ba(ddr3_ba), .ddr3_addr(ddr3_addr), .ref_busy(ref_busy), .ref_overrun(ref_overrun)
  );

  typedef struct packed {
    logic cs_n, ras_n, cas_n, we_n;
    logic [BW-1:0] ba;
    logic [AW-1:0] addr;
  } pins_t;
  typedef struct packed {
    logic [NB-1:0] grant;
    logic          ref_busy;
    logic          ref_overrun;
  } cyc_t;

  localparam pins_t RESET_PINS = '{cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1, ba: '0, addr: '0};

  pins_t pin_q [$];
  cyc_t  cyc_q [$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are compared mid-cycle against whatever the model queued for this cycle.
  pins_t mon_act, mon_exp;
  cyc_t  mon_cyc;
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mon_cyc = cyc_q.pop_front();
      check("grant", 64'(bank_cmd_grant), 64'(mon_cyc.grant));
      check("ref_busy", 64'(ref_busy), 64'(mon_cyc.ref_busy));
      check("ref_overrun", 64'(ref_overrun), 64'(mon_cyc.ref_overrun));
    end
    if (pin_q.size() > 0) begin
      mon_exp = pin_q.pop_front();
      mon_act = {ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n, ddr3_ba, ddr3_addr};
      check("pins", 64'(mon_act), 64'(mon_exp));
    end
  end

  // Reference model: time is a cycle number; spacing rules are checked against the cycle of the last
  // command of each kind, refresh against the cycle REFRESH was issued.
  int    m_cycle, m_ptr, last_act, last_rw, last_wr, ref_cycle, last_grant;
  bit    m_pend, m_overrun;
  pins_t m_pins;

  task automatic model_reset();
    m_cycle = 0; m_ptr = 0; last_grant = -1;
    last_act = -1000; last_rw = -1000; last_wr = -1000; ref_cycle = -1000;
    m_pend = 1'b0; m_overrun = 1'b0;
    m_pins = RESET_PINS;
  endtask

  function automatic bit model_eligible(input int b, input bit pend0);
    if (!bank_cmd_valid[BW'(b)]) return 1'b0;
    case (bank_cmd_type[b])
      CMD_ACT:   return (m_cycle - last_act >= TRRD) && !pend0;
      CMD_READ:  return (m_cycle - last_rw >= TCCD) && (m_cycle - last_wr >= TWTR);
      CMD_WRITE: return (m_cycle - last_rw >= TCCD);
      CMD_PRE:   return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    int g;
    bit blocked, pend0;
    cyc_t c;
    pins_t p;
    pend0   = m_pend;
    blocked = REF_EN && (m_cycle - ref_cycle >= 1) && (m_cycle - ref_cycle <= TRFC);
    g = -1;
    if (!blocked)
      for (int i = 0; i < NB; i++)
        if (g < 0 && model_eligible((m_ptr + i) % NB, pend0)) g = (m_ptr + i) % NB;
    c.grant = (g >= 0) ? (NB'(1) << g) : '0;
    c.ref_busy = pend0 || blocked;
    c.ref_overrun = m_overrun;
    cyc_q.push_back(c);

    p = m_pins;
    p.cs_n = 1'b0;
    {p.ras_n, p.cas_n, p.we_n} = 3'b111;
    if (g >= 0) begin
      p.ba = BW'(g);
      p.addr = bank_cmd_addr[g];
      case (bank_cmd_type[g])
        CMD_ACT:   begin {p.ras_n, p.cas_n, p.we_n} = 3'b011; last_act = m_cycle; end
        CMD_READ:  begin {p.ras_n, p.cas_n, p.we_n} = 3'b101; last_rw = m_cycle; end
        CMD_WRITE: begin {p.ras_n, p.cas_n, p.we_n} = 3'b100; last_rw = m_cycle; last_wr = m_cycle; end
        default:   {p.ras_n, p.cas_n, p.we_n} = 3'b010;
      endcase
      m_ptr = (g + 1) % NB;
    end else if (REF_EN && pend0 && !blocked && bank_busy == '0) begin
      {p.ras_n, p.cas_n, p.we_n} = 3'b001;
      p.ba = '0;
      p.addr = '0;
      m_pend = 1'b0;
      ref_cycle = m_cycle;
    end
    m_pins = p;
    pin_q.push_back(p);

    if (REF_EN && (m_cycle % TREFI == TREFI - 1)) begin
      if (pend0) m_overrun = 1'b1;
      m_pend = 1'b1;
    end
    last_grant = g;
    m_cycle++;
  endtask

  // One clock: model the current inputs, advance, then retire the granted request.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (last_grant >= 0) bank_cmd_valid[BW'(last_grant)] = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    cyc_q.delete();
    pin_q.delete();
    pin_q.push_back(RESET_PINS);
    repeat (cycles) begin
      cyc_q.push_back('{grant: '0, ref_busy: 1'b0, ref_overrun: 1'b0});
      pin_q.push_back(RESET_PINS);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_req(input int b, input ddr3_cmd_t t);
    bank_cmd_valid[BW'(b)] = 1'b1;
    bank_cmd_type[b] = t;
    bank_cmd_addr[b] = AW'($urandom);
  endtask

  task automatic rand_reqs();
    int r;
    for (int b = 0; b < NB; b++) begin
      if (bank_cmd_valid[BW'(b)] && bank_cmd_type[b] == CMD_NOP) begin
        if ($urandom_range(3) == 0) bank_cmd_valid[BW'(b)] = 1'b0;
      end else if (!bank_cmd_valid[BW'(b)] && $urandom_range(2) == 0) begin
        r = int'($urandom_range(15));
        if (r == 0)      set_req(b, CMD_NOP);
        else if (r < 5)  set_req(b, CMD_ACT);
        else if (r < 9)  set_req(b, CMD_READ);
        else if (r < 13) set_req(b, CMD_WRITE);
        else             set_req(b, CMD_PRE);
      end
    end
    bank_busy = ($urandom_range(3) == 0) ? NB'($urandom) : '0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(3);
    repeat (10) tick();

    // All four banks precharge together: strict rotation 0..3.
    for (int b = 0; b < NB; b++) set_req(b, CMD_PRE);
    repeat (6) tick();

    // Back-to-back activates spaced by tRRD.
    set_req(0, CMD_ACT);
    tick();
    set_req(1, CMD_ACT);
    repeat (6) tick();

    // Write then read: read waits for the larger of tCCD and tWTR.
    set_req(2, CMD_WRITE);
    tick();
    set_req(3, CMD_READ);
    repeat (8) tick();

    // A tRRD-blocked activate must not hold back a precharge.
    set_req(2, CMD_ACT);
    tick();
    set_req(0, CMD_ACT);
    set_req(1, CMD_PRE);
    repeat (6) tick();

    // A valid NOP request is never granted.
    set_req(3, CMD_NOP);
    repeat (4) tick();
    bank_cmd_valid = '0;
    repeat (2) tick();

    repeat (600) begin
      rand_reqs();
      tick();
    end

    // Reset with requests still asserted, then keep going.
    do_reset(2);
    repeat (150) begin
      rand_reqs();
      tick();
    end

    // Refresh window with all banks closed, then an activate arriving during it.
    bank_cmd_valid = '0;
    bank_busy = '0;
    do_reset(2);
    repeat (TREFI + 1) tick();
    set_req(0, CMD_ACT);
    repeat (14) tick();
    bank_busy = '1;
    repeat (40) tick();
    bank_busy = '0;
    repeat (20) tick();

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
